mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
// - Synthesizable, parametrised self-check monitor; snoops the data-memory write port of riscv.
// - Verifies a loaded table of expected writes (addr, size, value, cycle) against actual stores.
// - Each check has a +/-WINDOW cycle tolerance; pass/fail counters and first-failure capture are reported.
// - Replaces fixed-cycle polling of memory; reusable in benches and on FPGA.
// PARAMETERS
// NB_CHECKS  32  table depth (max expected writes per run)
// ADDR_W     32  data-memory address width
// CYCLE_W    16  cycle-counter width
// PIPE_DEPTH 3   offset added to exp_cycle (instruction issue -> store commit)
// WINDOW     2   tolerance in cycles either side of the target cycle
// PORTS
// clk         in   1       clock
// rst         in   1       async active-high reset
// ld_valid    in   1       push one table entry (accepted only in IDLE)
// ld_cycle    in   CYCLE_W expected issue cycle
// ld_addr     in   ADDR_W  expected byte address
// ld_size     in   2       0=byte 1=half 2=word (3 reserved)
// ld_value    in   32      expected value, LSB-aligned
// ld_full     out  1       table holds NB_CHECKS entries
// start       in   1       IDLE->RUN; clears cycle counter and result counters
// abort       in   1       RUN->DONE; remaining entries counted as fail
// mem_we      in   1       snooped store strobe
// mem_addr    in   ADDR_W  snooped store address
// mem_be      in   4       snooped byte enables
// mem_wdata   in   32      snooped store data, lane-aligned
// busy        out  1       state==RUN
// done        out  1       state==DONE (level)
// all_pass    out  1       done && fail_cnt==0 && pass_cnt==entries
// pass_cnt    out  $clog2(NB_CHECKS+1)  passed entries
// fail_cnt    out  $clog2(NB_CHECKS+1)  failed entries
// fail_idx    out  $clog2(NB_CHECKS)    index of first failing entry
// fail_got    out  32      last matching-address data seen for that entry (0 if none)
// order_err   out  1       sticky: an entry was loaded with ld_cycle < previous ld_cycle
// BEHAVIOUR
// - Reset: state IDLE, table count 0, all outputs 0, cycle counter 0.
// - FSM: IDLE -(start && count>0)-> RUN -(last entry resolved | abort)-> DONE -(start)-> RUN (table kept).
//   start with count==0 goes straight to DONE with all_pass=1. ld_valid outside IDLE ignored.
// - Load: ld_valid in IDLE writes entry[count], count++; when count==NB_CHECKS entry dropped, ld_full=1.
// - Cycle counter: cleared by start, +1 per clk in RUN, saturates at all-ones (no wrap).
// - One active entry at a time, in table order. T = exp_cycle + PIPE_DEPTH (CYCLE_W+1 bits, no overflow).
//   Window opens at max(T-WINDOW,0), closes at T+WINDOW inclusive.
// - Match: mem_we && word(mem_addr)==word(exp_addr) && mem_be covers the size lanes at exp_addr[1:0]
//   && lanes equal ld_value -> PASS; pass_cnt++; advance the next cycle. Writes outside the window
//   are ignored; writes inside with the same address but wrong data update fail_got; no fail yet.
// - Timeout: counter > T+WINDOW with no match -> FAIL; fail_cnt++; capture fail_idx/fail_got on the first fail only.
// - Misaligned entry (half at odd addr, word not %4) or size 3 -> immediate FAIL when it becomes active.
// - At most one entry resolves per cycle; a pass and a timeout never both occur (match checked first).
// - Counter saturated before T+WINDOW reached: pending entries time out normally.
// - abort: every unresolved entry is added to fail_cnt in that cycle; fail_idx = active entry if no prior fail.
// - rst mid-run: full clear including table; no partial results kept.
// STRUCTURE
// - Package riscv_check_pkg: chk_size_e, chk_state_e {IDLE,RUN,DONE}, check_t struct {cycle,addr,size,value}.
// - Sub-module check_table: NB_CHECKS x check_t register file, 1 write port, 1 async read port
//   (index = active pointer). Top-level holds FSM, counters, lane-mask compare.
// TESTING
// - 3 entries (word@4=0x0F0F0F0D c=10, half@16=0xFFC0 c=20, byte@22=0x01 c=30); exact stores at T
//   -> pass_cnt=3, fail_cnt=0, all_pass=1.
// - Store of word@4 at T+WINDOW passes; the same store at T+WINDOW+1 fails -> fail_idx=0, fail_got=store data.
// - Wrong data 0x12345678 to the expected address in the window, then no correct store
//   -> FAIL, fail_got=0x12345678.
// - Byte entry @23=0x0F, store with mem_be=4'b1000 data 0x0F000000 -> pass; mem_be=4'b0100 -> timeout fail.
// - Load NB_CHECKS+1 entries -> ld_full=1, last entry dropped; descending ld_cycle -> order_err=1.
// - abort after 1 of 4 passes -> done=1, pass_cnt=1, fail_cnt=3; rst asserted mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: table entry layout, FSM states, lane helpers.
package riscv_check_pkg;

    localparam int CHK_ADDR_W  = 32;
    localparam int CHK_CYCLE_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } chk_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic [CHK_CYCLE_W-1:0] cycle;
        logic [CHK_ADDR_W-1:0]  addr;
        chk_size_e              size;
        logic [31:0]            value;
    } check_t;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(chk_size_e size, logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(chk_size_e size, logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Table-load, control, store-snoop and result signals of the write checker.
interface mem_write_checker_if
    import riscv_check_pkg::*;
#(
    parameter int NB_CHECKS = 32,
    parameter int ADDR_W    = 32,
    parameter int CYCLE_W   = 16
);
    localparam int CNT_W = $clog2(NB_CHECKS + 1);
    localparam int IDX_W = (NB_CHECKS > 1) ? $clog2(NB_CHECKS) : 1;

    logic               ld_valid;
    logic [CYCLE_W-1:0] ld_cycle;
    logic [ADDR_W-1:0]  ld_addr;
    chk_size_e          ld_size;
    logic [31:0]        ld_value;
    logic               ld_full;
    logic               start;
    logic               abort;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic               busy;
    logic               done;
    logic               all_pass;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [IDX_W-1:0]   fail_idx;
    logic [31:0]        fail_got;
    logic               order_err;

    modport master (
        output ld_valid, ld_cycle, ld_addr, ld_size, ld_value, start, abort,
               mem_we, mem_addr, mem_be, mem_wdata,
        input  ld_full, busy, done, all_pass, pass_cnt, fail_cnt, fail_idx, fail_got, order_err
    );

    modport slave (
        input  ld_valid, ld_cycle, ld_addr, ld_size, ld_value, start, abort,
               mem_we, mem_addr, mem_be, mem_wdata,
        output ld_full, busy, done, all_pass, pass_cnt, fail_cnt, fail_idx, fail_got, order_err
    );
endinterface

// File: rtl/mem_write_checker_check_table.sv
// Expected-write table: one write port at the load pointer, asynchronous read at the active pointer.
module check_table
    import riscv_check_pkg::*;
#(
    parameter int NB_CHECKS = 32,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  check_t           wdata,
    input  logic [IDX_W-1:0] raddr,
    output check_t           rdata
);
    check_t               entry_reg [NB_CHECKS];
    logic [NB_CHECKS-1:0] wsel;

    generate
        for (genvar gi = 0; gi < NB_CHECKS; gi++) begin : g_wsel
            assign wsel[gi] = we && (waddr == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_CHECKS; i++) entry_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NB_CHECKS; i++)
                if (wsel[i]) entry_reg[i] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < NB_CHECKS) ? entry_reg[raddr] : '0;
endmodule

// File: rtl/mem_write_checker.sv
// Snoops data-memory stores and scores them against a table of expected (addr, size, value, cycle) writes.
module mem_write_checker
    import riscv_check_pkg::*;
#(
    parameter int NB_CHECKS  = 32,
    parameter int ADDR_W     = 32,
    parameter int CYCLE_W    = 16,
    parameter int PIPE_DEPTH = 3,
    parameter int WINDOW     = 2
) (
    input logic               clk,
    input logic               rst,
    mem_write_checker_if.slave bus
);
    localparam int CNT_W = $clog2(NB_CHECKS + 1);
    localparam int IDX_W = (NB_CHECKS > 1) ? $clog2(NB_CHECKS) : 1;
    localparam int TW    = CYCLE_W + 2;

    chk_state_e         state_reg;
    logic [CNT_W-1:0]   count_reg, ptr_reg, pass_reg, fail_reg;
    logic [IDX_W-1:0]   fail_idx_reg;
    logic [31:0]        got_reg, fail_got_reg;
    logic [CYCLE_W-1:0] cyc_reg, last_cycle_reg;
    logic               order_err_reg;

    check_t wr_entry, act;
    logic   load_ok;

    always_comb begin
        wr_entry       = '0;
        wr_entry.cycle = CHK_CYCLE_W'(bus.ld_cycle);
        wr_entry.addr  = CHK_ADDR_W'(bus.ld_addr);
        wr_entry.size  = bus.ld_size;
        wr_entry.value = bus.ld_value;
    end

    assign load_ok = bus.ld_valid && (state_reg == IDLE) && (count_reg != CNT_W'(NB_CHECKS));

    check_table #(.NB_CHECKS(NB_CHECKS), .IDX_W(IDX_W)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (load_ok),
        .waddr (count_reg[IDX_W-1:0]),
        .wdata (wr_entry),
        .raddr (ptr_reg[IDX_W-1:0]),
        .rdata (act)
    );

    // Active-entry evaluation against the store seen this cycle.
    logic [ADDR_W-1:0] act_addr;
    logic [1:0]        off;
    logic [3:0]        lmask;
    logic [31:0]       bmask, exp_lanes, seen_data, got_cur;
    logic [TW-1:0]     t_target, win_open, win_close, cyc_ext;
    logic              active, bad_entry, addr_hit, data_ok, in_window, cyc_sat;
    logic              hit_pass, hit_fail, last_entry;

    assign act_addr   = ADDR_W'(act.addr);
    assign off        = act_addr[1:0];
    assign lmask      = lane_mask(act.size, off);
    assign bmask      = lane_bits(lmask);
    assign exp_lanes  = (act.value << {off, 3'b000}) & bmask;
    assign seen_data  = (bus.mem_wdata & bmask) >> {off, 3'b000};
    assign t_target   = TW'(CYCLE_W'(act.cycle)) + TW'(PIPE_DEPTH);
    assign win_open   = (t_target >= TW'(WINDOW)) ? t_target - TW'(WINDOW) : '0;
    assign win_close  = t_target + TW'(WINDOW);
    assign cyc_ext    = TW'(cyc_reg);
    assign cyc_sat    = &cyc_reg;
    assign in_window  = (cyc_ext >= win_open) && (cyc_ext <= win_close);
    assign active     = (state_reg == RUN) && (ptr_reg != count_reg);
    assign bad_entry  = misaligned(act.size, off);
    assign addr_hit   = bus.mem_we && ((bus.mem_addr >> 2) == (act_addr >> 2))
                        && (lmask != 4'b0000) && ((bus.mem_be & lmask) == lmask);
    assign data_ok    = (bus.mem_wdata & bmask) == exp_lanes;
    // A late store still counts as "data seen", so a timeout reports what actually arrived.
    assign got_cur    = (addr_hit && !bad_entry && cyc_ext >= win_open) ? seen_data : got_reg;
    assign hit_pass   = active && !bad_entry && addr_hit && in_window && data_ok;
    assign hit_fail   = active && !hit_pass && (bad_entry || cyc_ext > win_close || cyc_sat);
    assign last_entry = (ptr_reg + CNT_W'(1)) == count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            ptr_reg        <= '0;
            pass_reg       <= '0;
            fail_reg       <= '0;
            fail_idx_reg   <= '0;
            got_reg        <= '0;
            fail_got_reg   <= '0;
            cyc_reg        <= '0;
            last_cycle_reg <= '0;
            order_err_reg  <= 1'b0;
        end else begin
            if (load_ok) begin
                count_reg      <= count_reg + CNT_W'(1);
                last_cycle_reg <= bus.ld_cycle;
                if (count_reg != '0 && bus.ld_cycle < last_cycle_reg) order_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        cyc_reg      <= '0;
                        ptr_reg      <= '0;
                        pass_reg     <= '0;
                        fail_reg     <= '0;
                        fail_idx_reg <= '0;
                        fail_got_reg <= '0;
                        got_reg      <= '0;
                        state_reg    <= (count_reg == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!cyc_sat) cyc_reg <= cyc_reg + CYCLE_W'(1);
                    if (bus.abort) begin
                        fail_reg <= fail_reg + (count_reg - ptr_reg);
                        if (fail_reg == '0) begin
                            fail_idx_reg <= ptr_reg[IDX_W-1:0];
                            fail_got_reg <= got_cur;
                        end
                        ptr_reg   <= count_reg;
                        state_reg <= DONE;
                    end else if (hit_pass || hit_fail) begin
                        if (hit_pass) begin
                            pass_reg <= pass_reg + CNT_W'(1);
                        end else begin
                            fail_reg <= fail_reg + CNT_W'(1);
                            if (fail_reg == '0) begin
                                fail_idx_reg <= ptr_reg[IDX_W-1:0];
                                fail_got_reg <= got_cur;
                            end
                        end
                        ptr_reg <= ptr_reg + CNT_W'(1);
                        got_reg <= '0;
                        if (last_entry) state_reg <= DONE;
                    end else begin
                        got_reg <= got_cur;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ld_full   = count_reg == CNT_W'(NB_CHECKS);
    assign bus.busy      = state_reg == RUN;
    assign bus.done      = state_reg == DONE;
    assign bus.all_pass  = (state_reg == DONE) && (fail_reg == '0) && (pass_reg == count_reg);
    assign bus.pass_cnt  = pass_reg;
    assign bus.fail_cnt  = fail_reg;
    assign bus.fail_idx  = fail_idx_reg;
    assign bus.fail_got  = fail_got_reg;
    assign bus.order_err = order_err_reg;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: exact, late, wrong-data, lane, overflow, abort and reset scenarios.
module tb_mem_write_checker;
    import riscv_check_pkg::*;

    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tb_cyc   = 0;

    always #5 clk = ~clk;

    mem_write_checker_if #(.NB_CHECKS(NB), .ADDR_W(32), .CYCLE_W(16)) bus ();

    mem_write_checker #(.NB_CHECKS(NB), .ADDR_W(32), .CYCLE_W(16), .PIPE_DEPTH(3), .WINDOW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_cycle  = '0;
        bus.ld_addr   = '0;
        bus.ld_size   = SZ_BYTE;
        bus.ld_value  = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] c, input logic [31:0] a, input chk_size_e s, input logic [31:0] v);
        bus.ld_valid = 1'b1;
        bus.ld_cycle = c;
        bus.ld_addr  = a;
        bus.ld_size  = s;
        bus.ld_value = v;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    // After this returns the DUT is in its first RUN cycle (cycle counter 0).
    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tb_cyc    = 0;
    endtask

    task automatic goto(input int k);
        while (tb_cyc < k) tick();
    endtask

    task automatic store(input int k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        goto(k);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = a;
        bus.mem_be    = be;
        bus.mem_wdata = d;
        tick();
        bus.mem_we    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!bus.done && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic report(input string name);
        $display("%s: done=%0d pass=%0d fail=%0d idx=%0d got=0x%08h all_pass=%0d",
                 name, bus.done, bus.pass_cnt, bus.fail_cnt, bus.fail_idx, bus.fail_got, bus.all_pass);
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_all_pass", 32'(bus.all_pass), 0);
        chk("rst_pass", 32'(bus.pass_cnt), 0);
        chk("rst_fail", 32'(bus.fail_cnt), 0);
        chk("rst_full", 32'(bus.ld_full), 0);
        chk("rst_order", 32'(bus.order_err), 0);

        // Three exact stores at T = cycle + 3.
        load(16'd10, 32'd4, SZ_WORD, 32'h0F0F0F0D);
        load(16'd20, 32'd16, SZ_HALF, 32'h0000FFC0);
        load(16'd30, 32'd22, SZ_BYTE, 32'h00000001);
        do_start();
        chk("t1_busy", 32'(bus.busy), 1);
        store(13, 32'd4, 4'b1111, 32'h0F0F0F0D);
        store(23, 32'd16, 4'b0011, 32'h0000FFC0);
        store(33, 32'd20, 4'b0100, 32'h00010000);
        wait_done("t1_done", 20);
        report("exact");
        chk("t1_pass", 32'(bus.pass_cnt), 3);
        chk("t1_fail", 32'(bus.fail_cnt), 0);
        chk("t1_all_pass", 32'(bus.all_pass), 1);

        // Window edge: T+2 passes, T+3 times out with the late data captured.
        do_reset();
        load(16'd10, 32'd4, SZ_WORD, 32'h0F0F0F0D);
        do_start();
        store(15, 32'd4, 4'b1111, 32'h0F0F0F0D);
        wait_done("t2a_done", 20);
        report("edge_in");
        chk("t2a_pass", 32'(bus.pass_cnt), 1);
        chk("t2a_all_pass", 32'(bus.all_pass), 1);
        do_start();
        store(16, 32'd4, 4'b1111, 32'h0F0F0F0D);
        wait_done("t2b_done", 20);
        report("edge_out");
        chk("t2b_pass", 32'(bus.pass_cnt), 0);
        chk("t2b_fail", 32'(bus.fail_cnt), 1);
        chk("t2b_idx", 32'(bus.fail_idx), 0);
        chk("t2b_got", bus.fail_got, 32'h0F0F0F0D);
        chk("t2b_all_pass", 32'(bus.all_pass), 0);

        // Wrong data inside the window, never corrected.
        do_reset();
        load(16'd10, 32'd4, SZ_WORD, 32'h0F0F0F0D);
        do_start();
        store(12, 32'd4, 4'b1111, 32'h12345678);
        chk("t3_busy_mid", 32'(bus.busy), 1);
        wait_done("t3_done", 20);
        report("wrong_data");
        chk("t3_fail", 32'(bus.fail_cnt), 1);
        chk("t3_got", bus.fail_got, 32'h12345678);

        // Byte lane 3: correct lane passes, wrong lane times out.
        do_reset();
        load(16'd10, 32'd23, SZ_BYTE, 32'h0000000F);
        do_start();
        store(13, 32'd20, 4'b1000, 32'h0F000000);
        wait_done("t4a_done", 20);
        report("lane_ok");
        chk("t4a_pass", 32'(bus.pass_cnt), 1);
        do_start();
        store(13, 32'd20, 4'b0100, 32'h0F000000);
        wait_done("t4b_done", 20);
        report("lane_bad");
        chk("t4b_fail", 32'(bus.fail_cnt), 1);
        chk("t4b_pass", 32'(bus.pass_cnt), 0);
        chk("t4b_got", bus.fail_got, 32'h0);

        // Table overflow and descending cycle order, then abort in the first RUN cycle.
        do_reset();
        for (int i = 0; i < NB - 1; i++) load(16'(2 * i), 32'(4 * i), SZ_WORD, 32'(i));
        chk("t5_full_pre", 32'(bus.ld_full), 0);
        chk("t5_order_pre", 32'(bus.order_err), 0);
        load(16'd5, 32'd64, SZ_WORD, 32'h55);
        chk("t5_full", 32'(bus.ld_full), 1);
        chk("t5_order", 32'(bus.order_err), 1);
        load(16'd50, 32'd68, SZ_WORD, 32'h66);
        do_start();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        report("overflow_abort");
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_fail", 32'(bus.fail_cnt), NB);
        chk("t5_idx", 32'(bus.fail_idx), 0);

        // Abort after one of four passes.
        do_reset();
        for (int i = 0; i < 4; i++) load(16'(10 * (i + 1)), 32'(4 * i), SZ_WORD, 32'h100 + 32'(i));
        do_start();
        store(13, 32'd0, 4'b1111, 32'h100);
        goto(18);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        report("abort");
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_pass", 32'(bus.pass_cnt), 1);
        chk("t6_fail", 32'(bus.fail_cnt), 3);
        chk("t6_idx", 32'(bus.fail_idx), 1);

        // Asynchronous reset mid-run clears everything including the table.
        do_start();
        store(13, 32'd0, 4'b1111, 32'h100);
        chk("t7_pass_mid", 32'(bus.pass_cnt), 1);
        goto(15);
        #3;
        rst = 1'b1;
        #1;
        report("async_rst");
        chk("t7_busy", 32'(bus.busy), 0);
        chk("t7_done", 32'(bus.done), 0);
        chk("t7_pass", 32'(bus.pass_cnt), 0);
        chk("t7_all_pass", 32'(bus.all_pass), 0);
        tick();
        rst = 1'b0;
        do_start();
        chk("t7_empty_done", 32'(bus.done), 1);
        chk("t7_empty_all_pass", 32'(bus.all_pass), 1);

        // Misaligned half-word fails as soon as it becomes active.
        do_reset();
        load(16'd5, 32'd17, SZ_HALF, 32'h1234);
        do_start();
        wait_done("t8_done", 5);
        report("misaligned");
        chk("t8_fail", 32'(bus.fail_cnt), 1);
        chk("t8_pass", 32'(bus.pass_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
